rf_wb_arbiter: RTL

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges the ALU and LSU result channels onto a single
// registered register-file write port.
//   - ALU results have priority and take 1 cycle to reach the write port.
//   - LSU results pass through a 2-entry FIFO, so they take at least 2 cycles.
//   - A starvation counter forces the FIFO head through after the ALU has won
//     STARVE_LIMIT consecutive cycles while the FIFO was waiting.
//   - Writes to register 0 are consumed but never raise wEN.
// Optional macro WB_FORWARD_EN adds a combinational bypass lookup against the
// registered write port; without it the bypass outputs are tied to zero.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int RF_ADDR_WIDTH = 5,
    parameter int STARVE_LIMIT  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // ALU result channel
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [RF_ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    // Load / mul-div result channel
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [RF_ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0]    lsu_data,
    // Register-file write port
    output logic                     wEN,
    output logic [RF_ADDR_WIDTH-1:0] wAddr,
    output logic [DATA_WIDTH-1:0]    wData,
    // Bypass lookup
    input  logic [RF_ADDR_WIDTH-1:0] fwd_addr1,
    input  logic [RF_ADDR_WIDTH-1:0] fwd_addr2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [DATA_WIDTH-1:0]    fwd_data1,
    output logic [DATA_WIDTH-1:0]    fwd_data2
);

    // Counter must be able to hold STARVE_LIMIT itself.
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_LSU  = 2'd2
    } sel_e;

    // LSU FIFO state
    logic [RF_ADDR_WIDTH-1:0] fifo_rd_q   [2];
    logic [DATA_WIDTH-1:0]    fifo_data_q [2];
    logic [1:0]               count_q, count_d;
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;

    // Arbitration state
    logic [SW-1:0]            starve_q, starve_d;

    // Output stage
    logic                     wen_q, wen_d;
    logic [RF_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;

    // Combinational helpers
    logic                     fifo_nonempty_s;
    logic                     starved_s;
    logic                     lsu_push_s;
    logic                     fifo_pop_s;
    sel_e                     sel_s;
    logic [RF_ADDR_WIDTH-1:0] sel_rd_s;
    logic [DATA_WIDTH-1:0]    sel_data_s;

    // Handshake readiness: LSU side depends only on the registered count.
    always_comb begin
        fifo_nonempty_s = (count_q != 2'd0);
        starved_s       = fifo_nonempty_s && (starve_q == STARVE_MAX);
        lsu_ready       = rst_n && (count_q != 2'd2);
        alu_ready       = rst_n && !starved_s;
        lsu_push_s      = lsu_valid && lsu_ready;
    end

    // Pick at most one candidate: starved FIFO head, then ALU, then FIFO head.
    always_comb begin
        sel_s = SEL_NONE;
        if (!rst_n) begin
            sel_s = SEL_NONE;
        end else if (starved_s) begin
            sel_s = SEL_LSU;
        end else if (alu_valid) begin
            sel_s = SEL_ALU;
        end else if (fifo_nonempty_s) begin
            sel_s = SEL_LSU;
        end else begin
            sel_s = SEL_NONE;
        end
    end

    // Payload of the selected candidate.
    always_comb begin
        sel_rd_s   = {RF_ADDR_WIDTH{1'b0}};
        sel_data_s = {DATA_WIDTH{1'b0}};
        case (sel_s)
            SEL_ALU: begin
                sel_rd_s   = alu_rd;
                sel_data_s = alu_data;
            end
            SEL_LSU: begin
                sel_rd_s   = fifo_rd_q[rd_ptr_q];
                sel_data_s = fifo_data_q[rd_ptr_q];
            end
            default: begin
                sel_rd_s   = {RF_ADDR_WIDTH{1'b0}};
                sel_data_s = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // FIFO pointer/count next state; a head can never pop in its push cycle.
    always_comb begin
        fifo_pop_s = (sel_s == SEL_LSU);
        count_d    = count_q + {1'b0, lsu_push_s} - {1'b0, fifo_pop_s};
        wr_ptr_d   = wr_ptr_q ^ lsu_push_s;
        rd_ptr_d   = rd_ptr_q ^ fifo_pop_s;
    end

    // Starvation counter: counts ALU wins while the FIFO waits.
    always_comb begin
        starve_d = {SW{1'b0}};
        case (sel_s)
            SEL_ALU: begin
                if (fifo_nonempty_s) begin
                    starve_d = starve_q + SW'(1);
                end else begin
                    starve_d = {SW{1'b0}};
                end
            end
            SEL_LSU:  starve_d = {SW{1'b0}};
            default:  starve_d = {SW{1'b0}};
        endcase
    end

    // Output stage next state: register 0 is consumed silently; address and
    // data only move on a real write so they hold through idle cycles.
    always_comb begin
        wen_d   = (sel_s != SEL_NONE) && (sel_rd_s != {RF_ADDR_WIDTH{1'b0}});
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (wen_d) begin
            waddr_d = sel_rd_s;
            wdata_d = sel_data_s;
        end else begin
            waddr_d = waddr_q;
            wdata_d = wdata_q;
        end
    end

    // Control and output-stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            starve_q <= {SW{1'b0}};
            wen_q    <= 1'b0;
            waddr_q  <= {RF_ADDR_WIDTH{1'b0}};
            wdata_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            starve_q <= starve_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // FIFO storage: capture the LSU payload on an accepted transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_rd_q[0]   <= {RF_ADDR_WIDTH{1'b0}};
            fifo_rd_q[1]   <= {RF_ADDR_WIDTH{1'b0}};
            fifo_data_q[0] <= {DATA_WIDTH{1'b0}};
            fifo_data_q[1] <= {DATA_WIDTH{1'b0}};
        end else if (lsu_push_s) begin
            fifo_rd_q[wr_ptr_q]   <= lsu_rd;
            fifo_data_q[wr_ptr_q] <= lsu_data;
        end
    end

    assign wEN   = wen_q;
    assign wAddr = waddr_q;
    assign wData = wdata_q;

`ifdef WB_FORWARD_EN
    // Bypass lookup against the write currently on the port; x0 never hits.
    always_comb begin
        fwd_hit1  = wen_q && (waddr_q == fwd_addr1) &&
                    (fwd_addr1 != {RF_ADDR_WIDTH{1'b0}});
        fwd_hit2  = wen_q && (waddr_q == fwd_addr2) &&
                    (fwd_addr2 != {RF_ADDR_WIDTH{1'b0}});
        fwd_data1 = {DATA_WIDTH{1'b0}};
        fwd_data2 = {DATA_WIDTH{1'b0}};
        if (fwd_hit1) begin
            fwd_data1 = wdata_q;
        end else begin
            fwd_data1 = {DATA_WIDTH{1'b0}};
        end
        if (fwd_hit2) begin
            fwd_data2 = wdata_q;
        end else begin
            fwd_data2 = {DATA_WIDTH{1'b0}};
        end
    end
`else
    // Bypass disabled: outputs tied off, lookup addresses intentionally unused.
    logic unused_fwd_s;
    assign unused_fwd_s = ^{fwd_addr1, fwd_addr2};
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = {DATA_WIDTH{1'b0}};
    assign fwd_data2 = {DATA_WIDTH{1'b0}};
`endif

endmodule
